// File: rtl/fifo_rd_packer.sv
// Packs RATIO narrow FIFO words into one wide valid/ready beat, read-side of an async FIFO.
// A flush request closes a partial beat and marks the filled lanes in out_keep.
//
// state    | meaning
// ST_IDLE  | normal packing; pops allowed
// ST_FLUSH | flush accepted; waiting for a free output slot to emit the partial beat
module fifo_rd_packer #(
    parameter int DWIDTH = 4,
    parameter int RATIO  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DWIDTH-1:0]       fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_ren,
    input  logic                    flush,
    output logic                    flush_busy,
    output logic [RATIO*DWIDTH-1:0] out_data,
    output logic [RATIO-1:0]        out_keep,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int            CW   = $clog2(RATIO);
    localparam int            BW   = RATIO * DWIDTH;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    acc;
    logic             slot_free;
    logic [RATIO-1:0] part_keep;
    logic [BW-1:0]    part_mask;

    assign slot_free  = ~out_valid | out_ready;
    assign flush_busy = (state == ST_FLUSH);
    assign fifo_ren   = ~rst & ~fifo_empty & ~flush_busy & ((cnt != LAST) | slot_free);
    assign part_keep  = (RATIO'(1) << cnt) - RATIO'(1);

    // Stale lanes from an earlier beat stay in acc; mask them out of a partial beat.
    always_comb begin
        part_mask = '0;
        for (int i = 0; i < RATIO; i++) begin
            part_mask[i*DWIDTH +: DWIDTH] = {DWIDTH{part_keep[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end

            if (fifo_ren) begin
                acc[cnt*DWIDTH +: DWIDTH] <= fifo_dout;
                if (cnt == LAST) begin
                    out_data  <= {fifo_dout, acc[BW-DWIDTH-1:0]};
                    out_keep  <= '1;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        state <= ST_FLUSH;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else if (slot_free) begin
                        out_data  <= acc & part_mask;
                        out_keep  <= part_keep;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
